// File: rtl/mem_load_sequencer.sv
// Tile sequencer for the systolic array's memory interface: clear, N row loads, drain, done.
// Optional performance counters (tile_count, stall_count) are built when MEM_SEQ_PERF_CNT_EN is defined.
module mem_load_sequencer #(
    parameter int N      = 2,
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_top,
    input  logic [ADDR_W-1:0] base_left,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] addr_top,
    output logic [ADDR_W-1:0] addr_left,
    output logic              load,
    output logic              store,
    output logic              acc_clear,
    output logic              compute_en,
    output logic              busy,
    output logic              done
`ifdef MEM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       tile_count,
    output logic [31:0]       stall_count
`endif
);

    localparam int LOG_N   = $clog2(N);
    localparam int DRAIN_W = $clog2(2*N);
    localparam logic [ADDR_W-1:0]  K_LAST     = ADDR_W'(N-1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2*N-2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   k_reg, k_next;
    logic [DRAIN_W-1:0]  drain_reg, drain_next;
    logic [ADDR_W-1:0]   base_top_reg, base_top_next;
    logic [ADDR_W-1:0]   base_left_reg, base_left_next;
    logic [ADDR_W-1:0]   row_offset;

    // Rows are N entries apart; the shift truncates to ADDR_W, giving the mod N*N wrap.
    assign row_offset = k_reg << LOG_N;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            drain_reg     <= '0;
            base_top_reg  <= '0;
            base_left_reg <= '0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            drain_reg     <= drain_next;
            base_top_reg  <= base_top_next;
            base_left_reg <= base_left_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        drain_next     = drain_reg;
        base_top_next  = base_top_reg;
        base_left_next = base_left_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next     = S_CLEAR;
                    base_top_next  = base_top;
                    base_left_next = base_left;
                    k_next         = '0;
                    drain_next     = '0;
                end
            end
            S_CLEAR: begin
                state_next = S_LOAD;
                k_next     = '0;
            end
            S_LOAD: begin
                if (k_reg == K_LAST) begin
                    state_next = S_DRAIN;
                    drain_next = '0;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = S_DONE;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Reset blanks every output, even in the cycle before the state register clears.
    always_comb begin
        wr_ready   = 1'b0;
        store      = 1'b0;
        load       = 1'b0;
        acc_clear  = 1'b0;
        compute_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        addr_top   = '0;
        addr_left  = '0;
        if (!rst) begin
            case (state_reg)
                S_IDLE: begin
                    wr_ready = !start;
                    store    = wr_req && !start;
                    if (wr_req && !start) begin
                        addr_top  = wr_addr;
                        addr_left = wr_addr;
                    end
                end
                S_CLEAR: begin
                    busy      = 1'b1;
                    acc_clear = 1'b1;
                end
                S_LOAD: begin
                    busy       = 1'b1;
                    load       = 1'b1;
                    compute_en = (k_reg != '0);
                    addr_top   = base_top_reg + row_offset;
                    addr_left  = base_left_reg + row_offset;
                end
                S_DRAIN: begin
                    busy       = 1'b1;
                    compute_en = 1'b1;
                end
                S_DONE: begin
                    busy = 1'b1;
                    done = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_SEQ_PERF_CNT_EN
    logic [31:0] tile_count_reg;
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_count_reg  <= '0;
            stall_count_reg <= '0;
        end else begin
            if (state_reg == S_DONE && tile_count_reg != '1) begin
                tile_count_reg <= tile_count_reg + 1'b1;
            end
            if (wr_req && !wr_ready && stall_count_reg != '1) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

    assign tile_count  = rst ? '0 : tile_count_reg;
    assign stall_count = rst ? '0 : stall_count_reg;
`endif

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Randomized bench for mem_load_sequencer against a timeline model (cycles since start acceptance).
// Counter checks are compiled in when MEM_SEQ_PERF_CNT_EN is defined.
module tb_mem_load_sequencer;

    localparam int N  = 2;
    localparam int AW = $clog2(N*N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_top = '0;
    logic [AW-1:0] base_left = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_ready, load, store, acc_clear, compute_en, busy, done;
    logic [AW-1:0] addr_top, addr_left;
`ifdef MEM_SEQ_PERF_CNT_EN
    logic [31:0]   tile_count, stall_count;
`endif

    mem_load_sequencer #(.N(N), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_top   (base_top),
        .base_left  (base_left),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_ready   (wr_ready),
        .addr_top   (addr_top),
        .addr_left  (addr_left),
        .load       (load),
        .store      (store),
        .acc_clear  (acc_clear),
        .compute_en (compute_en),
        .busy       (busy),
        .done       (done)
`ifdef MEM_SEQ_PERF_CNT_EN
        ,
        .tile_count (tile_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model: t = 0 idle, otherwise cycles elapsed since the start edge.
    int t = 0;
    int m_base_top = 0;
    int m_base_left = 0;
    int m_tiles = 0;
    int m_stalls = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    endtask

    task automatic cycle(input logic s, input logic r, input logic wq,
                         input logic [AW-1:0] wa, input logic [AW-1:0] bt, input logic [AW-1:0] bl);
        logic          e_ready, e_store, e_load, e_clear, e_comp, e_busy, e_done;
        int            e_at, e_al, k;
        start = s; rst = r; wr_req = wq; wr_addr = wa; base_top = bt; base_left = bl;
        @(negedge clk);
        e_ready = !r && (t == 0) && !s;
        e_store = e_ready && wq;
        e_clear = !r && (t == 1);
        e_load  = !r && (t >= 2) && (t <= N + 1);
        e_comp  = !r && (t >= 3) && (t <= 3 * N);
        e_busy  = !r && (t != 0);
        e_done  = !r && (t == 3 * N + 1);
        k = t - 2;
        e_at = 0; e_al = 0;
        if (e_load) begin
            e_at = (m_base_top + k * N) % (N * N);
            e_al = (m_base_left + k * N) % (N * N);
        end else if (e_store) begin
            e_at = int'(wa);
            e_al = int'(wa);
        end
        check("wr_ready", wr_ready, e_ready);
        check("store", store, e_store);
        check("load", load, e_load);
        check("acc_clear", acc_clear, e_clear);
        check("compute_en", compute_en, e_comp);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("addr_top", addr_top, e_at);
        check("addr_left", addr_left, e_al);
`ifdef MEM_SEQ_PERF_CNT_EN
        check("tile_count", tile_count, r ? 0 : m_tiles);
        check("stall_count", stall_count, r ? 0 : m_stalls);
`endif
        $display("cyc t=%0d rst=%0b start=%0b wr_req=%0b load=%0b store=%0b at=%0d al=%0d done=%0b",
                 t, r, s, wq, load, store, addr_top, addr_left, done);
        @(posedge clk);
        if (e_done) done_seen++;
        if (r) begin
            t = 0; m_tiles = 0; m_stalls = 0;
            m_base_top = 0; m_base_left = 0;
        end else begin
            if (e_done) m_tiles++;
            if (wq && !e_ready) m_stalls++;
            if (t == 0 && s) begin
                t = 1;
                m_base_top = int'(bt);
                m_base_left = int'(bl);
            end else if (t == 3 * N + 1) begin
                t = 0;
            end else if (t != 0) begin
                t++;
            end
        end
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        // Reset held with start and wr_req high
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        // Basic tile, bases 0/0
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        check("single_done", 32'(done_seen), 32'd1);
        // Address wrap, bases disturbed after acceptance
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 2'd1);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 2'd0, AW'($urandom), AW'($urandom));
        // Start beats a same-cycle store; store held until first idle cycle
        cycle(1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        // Start re-pulsed during drain is ignored
        done_seen = 0;
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd3);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        check("ignored_start_done", 32'(done_seen), 32'd1);
        // Reset during first LOAD cycle aborts the tile
        done_seen = 0;
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        check("abort_no_done", 32'(done_seen), 32'd0);
        // Back-to-back tiles, second start in the re-entry idle cycle
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1);
        repeat (7) cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd3);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        // Random traffic
        repeat (1500) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), AW'($urandom));
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mem_load_sequencer.md
# mem_load_sequencer

Controller that sequences the host-memory interface for one matrix-multiply tile. On `start` it clears the accumulators, issues N row-load cycles with stepped addresses, waits for the systolic array to drain, then pulses `done`. While idle, it arbitrates host write requests onto the memory interface's store path. It sits between the host/command logic and the memory interface that feeds the systolic array's top and left edges.

## Interface
- `N`, 2, array dimension; power of two, ≥2
- `ADDR_W`, `$clog2(N*N)`, memory address width
- `clk`  input  1  clock, all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  begin a tile; sampled only in IDLE
- `base_top`  input  ADDR_W  top-matrix base address; latched when start is accepted
- `base_left`  input  ADDR_W  left-matrix base address; latched when start is accepted
- `wr_req`  input  1  host store request
- `wr_addr`  input  ADDR_W  host store address
- `wr_ready`  output  1  store accepted this cycle when `wr_req` is also high
- `addr_top`  output  ADDR_W  memory-interface top address
- `addr_left`  output  ADDR_W  memory-interface left address
- `load`  output  1  memory-interface load strobe
- `store`  output  1  memory-interface store strobe
- `acc_clear`  output  1  one-cycle accumulator clear to the array
- `compute_en`  output  1  array processing-element enable
- `busy`  output  1  high in any state other than IDLE
- `done`  output  1  one-cycle tile-complete pulse

## Operation
- States:
  - IDLE → CLEAR on `start`.
  - CLEAR (1 cycle) → LOAD.
  - LOAD lasts N cycles, with counter k = 0..N-1 → DRAIN.
  - DRAIN lasts 2N-1 cycles → DONE.
  - DONE (1 cycle) → IDLE.
- `start` is accepted only in IDLE. In every other state it is ignored and is not queued.
- `base_top` and `base_left` are registered when `start` is accepted. Later changes to the inputs have no effect on the tile in progress.
- LOAD:
  - `load` = 1.
  - `addr_top` = (base_top_q + k·N) mod N², `addr_left` = (base_left_q + k·N) mod N².
  - Wrap-around is natural truncation to ADDR_W bits.
- CLEAR: `acc_clear` = 1; all other strobes are 0.
- `compute_en` = 1 from the second LOAD cycle through the last DRAIN cycle inclusive. This accounts for the memory interface's one-cycle registered read.
- DONE: `done` = 1, `busy` = 1, `compute_en` = 0.
- Store arbitration:
  - `wr_ready` = (state == IDLE) && !start && !rst.
  - `store` = wr_req && wr_ready.
  - While `store` = 1: `addr_top` = `addr_left` = `wr_addr`.
  - `start` wins over a same-cycle `wr_req`.
- Address outputs are 0 whenever neither `load` nor `store` is asserted.
- `load` and `store` are never high in the same cycle.
- All strobes are combinational decodes of registered state, the k counter and the latched bases. The only exception is the store path, which passes `wr_req`/`wr_addr` through combinationally in the same cycle.

## Timing
- Reset:
  - State = IDLE; k counter, drain counter and latched bases = 0.
  - Every output = 0 while `rst` is high, including `wr_ready`.
  - `rst` asserted mid-tile forces IDLE on the next edge. No `done` pulse is generated and the aborted tile is discarded.
- Given `start` accepted at edge T0:
  - CLEAR occupies cycle T0+1.
  - LOAD occupies T0+2 … T0+N+1.
  - DRAIN occupies T0+N+2 … T0+3N.
  - `done` is high during cycle T0+3N+1.
  - IDLE is re-entered at T0+3N+2; a new `start` may be accepted in that cycle.
- Tile latency, start acceptance to `done`: 3N+1 cycles. For N = 2 that is 7.
- `busy` = 1 from CLEAR through DONE inclusive.
- `wr_req` held while busy stalls with `wr_ready` = 0. It is served in the first IDLE cycle that has no `start`.

## Configuration
- `MEM_SEQ_PERF_CNT_EN`
  - Defined: adds output `tile_count` (32 bits), reset to 0 and incremented in each DONE cycle, saturating at 2³²-1. Also adds output `stall_count` (32 bits), reset to 0 and incremented in every cycle where `wr_req` && !`wr_ready` && !`rst`, saturating at 2³²-1.
  - Undefined: neither port nor any counter logic exists. All other behaviour is identical.

## Test plan
1. **Reset.** Hold `rst` 3 cycles with `start` = 1 and `wr_req` = 1 → all outputs 0 throughout. After release with both inputs low → `wr_ready` = 1, `busy` = 0.
2. **Basic tile.** N = 2, bases 0/0, `start` pulse at T0 → `acc_clear` at T0+1. `load` at T0+2 (addr 0/0) and T0+3 (addr 2/2). `compute_en` T0+3…T0+6. `done` only at T0+7. `busy` T0+1…T0+7.
3. **Address wrap.** `base_top` = 3, `base_left` = 1 → load addresses top 3,1 and left 1,3. Changing the bases after T0 does not alter these.
4. **Start vs. store.** IDLE with `start` = 1, `wr_req` = 1, `wr_addr` = 2 in the same cycle → `store` = 0 and the tile starts. `wr_req` held → `wr_ready` = 0 until IDLE, then `store` = 1 with `addr_top` = `addr_left` = 2 on the first IDLE cycle.
5. **Ignored start and mid-tile reset.** `start` re-pulsed during DRAIN → no effect and `done` occurs once. A second tile with `rst` asserted during its first LOAD cycle → IDLE next cycle, `load` = 0, no `done` pulse.
6. **Performance counters.** With `MEM_SEQ_PERF_CNT_EN` defined, two tiles run back to back → `tile_count` = 2. `wr_req` held through one full tile (7 busy cycles) → `stall_count` = 8, which includes the start cycle.
